// File: rtl/data_mem_resp.sv
`default_nettype none
// ============================================================================
//  Module   : data_mem_resp
//  Brief    : Single-port data memory for an in-order core with a fixed
//             wait-state response protocol (IDLE -> WAIT -> RESP), byte/half/
//             word loads and stores, and access-error reporting.
//  Revision : 1.0 - initial release
// ============================================================================
module data_mem_resp #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err
);

    localparam int         c_AW        = $clog2(DEPTH_WORDS);
    localparam logic [1:0] c_S_IDLE    = 2'd0;
    localparam logic [1:0] c_S_WAIT    = 2'd1;
    localparam logic [1:0] c_S_RESP    = 2'd2;
    localparam bit         c_HAS_WAIT  = (WAIT_CYCLES > 0);
    localparam logic [3:0] c_WAIT_LOAD = c_HAS_WAIT ? 4'(WAIT_CYCLES - 1) : 4'd0;

    logic [1:0]      state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            w_accept;

    // Request copies captured at acceptance; the datapath never looks at the
    // live inputs so the core may change them freely while we are busy.
    logic            we_q;
    logic [2:0]      funct3_q;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;

    logic [31:0]     mem_q [0:DEPTH_WORDS-1];

    logic [c_AW-1:0] w_idx;
    logic [31:0]     w_rword;
    logic [7:0]      w_byte;
    logic [15:0]     w_half;
    logic [31:0]     w_load;
    logic [3:0]      w_be;
    logic [31:0]     w_wlane;
    logic            w_bad_f3;
    logic            w_misalign;
    logic            w_oob;
    logic            w_err;
    logic            w_resp;
    logic            w_wr_en;

    // State register, wait counter and request capture
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= c_S_IDLE;
            cnt_q    <= 4'd0;
            we_q     <= 1'b0;
            funct3_q <= 3'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (w_accept) begin
                we_q     <= we;
                funct3_q <= funct3;
                addr_q   <= addr;
                wdata_q  <= wdata;
            end
        end
    end

    // Next-state logic: accept in IDLE, count down wait states, one RESP cycle
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        w_accept = 1'b0;
        case (state_q)
            c_S_IDLE: begin
                if (req_valid) begin
                    w_accept = 1'b1;
                    if (c_HAS_WAIT) begin
                        state_d = c_S_WAIT;
                        cnt_d   = c_WAIT_LOAD;
                    end else begin
                        state_d = c_S_RESP;
                    end
                end
            end
            c_S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = c_S_RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            c_S_RESP: begin
                state_d = c_S_IDLE;
                cnt_d   = 4'd0;
            end
            default: begin
                state_d = c_S_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
    end

    // Access checks: bad funct3 for the direction, misalignment, out of range
    assign w_bad_f3   = we_q ? (funct3_q[2] || (funct3_q[1:0] == 2'b11))
                             : ((funct3_q == 3'b011) || (funct3_q[2:1] == 2'b11));
    assign w_misalign = ((funct3_q[1:0] == 2'b01) && addr_q[0]) ||
                        ((funct3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
    assign w_oob      = (addr_q[31:c_AW+2] != '0);
    assign w_err      = w_bad_f3 || w_misalign || w_oob;

    assign w_idx   = addr_q[c_AW+1:2];
    assign w_rword = mem_q[w_idx];
    assign w_half  = addr_q[1] ? w_rword[31:16] : w_rword[15:0];

    // Little-endian byte select for byte loads
    always_comb begin
        w_byte = w_rword[7:0];
        case (addr_q[1:0])
            2'd0:    w_byte = w_rword[7:0];
            2'd1:    w_byte = w_rword[15:8];
            2'd2:    w_byte = w_rword[23:16];
            default: w_byte = w_rword[31:24];
        endcase
    end

    // Load width selection and sign/zero extension
    always_comb begin
        w_load = 32'd0;
        case (funct3_q)
            3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b010:  w_load = w_rword;
            3'b100:  w_load = {24'd0, w_byte};
            3'b101:  w_load = {16'd0, w_half};
            default: w_load = 32'd0;
        endcase
    end

    // Store lane enables with the right-aligned data replicated across lanes
    always_comb begin
        w_be    = 4'b0000;
        w_wlane = wdata_q;
        case (funct3_q)
            3'b000: begin
                w_be    = 4'b0001 << addr_q[1:0];
                w_wlane = {4{wdata_q[7:0]}};
            end
            3'b001: begin
                w_be    = addr_q[1] ? 4'b1100 : 4'b0011;
                w_wlane = {2{wdata_q[15:0]}};
            end
            3'b010:  w_be = 4'b1111;
            default: w_be = 4'b0000;
        endcase
    end

    // A store commits on the edge that ends RESP; a reset held low at that
    // edge has already dropped the state to IDLE, and is also gated here.
    assign w_wr_en = (state_q == c_S_RESP) && we_q && !w_err && reset;

    // Storage array: no reset, contents survive a reset pulse
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (w_be[b]) begin
                    mem_q[w_idx][8*b +: 8] <= w_wlane[8*b +: 8];
                end
            end
        end
    end

    // Response outputs: qualified by RESP so they read zero at all other times
    always_comb begin
        w_resp = (state_q == c_S_RESP);
        ready  = w_resp;
        err    = w_resp && w_err;
        rdata  = (w_resp && !we_q && !w_err) ? w_load : 32'd0;
    end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_resp.sv
`default_nettype none
// ============================================================================
//  Module   : tb_data_mem_resp
//  Brief    : Scoreboard bench for data_mem_resp. A byte-array reference model
//             predicts each response; a negedge monitor pops and compares.
//             A second instance with no wait states checks the back-to-back
//             cadence.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_resp;

    localparam int DEPTH  = 256;
    localparam int WAIT   = 2;
    localparam int NBYTES = DEPTH * 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        we = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic [31:0] rdata;
    logic        ready;
    logic        err;

    logic        z_req_valid = 1'b0;
    logic        z_we = 1'b0;
    logic [2:0]  z_funct3 = 3'd0;
    logic [31:0] z_addr = 32'd0;
    logic [31:0] z_wdata = 32'd0;
    logic [31:0] z_rdata;
    logic        z_ready;
    logic        z_err;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_mem_resp #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAIT)) u_dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .we(we),
        .funct3(funct3), .addr(addr), .wdata(wdata),
        .rdata(rdata), .ready(ready), .err(err)
    );

    data_mem_resp #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
        .clk(clk), .reset(reset), .req_valid(z_req_valid), .we(z_we),
        .funct3(z_funct3), .addr(z_addr), .wdata(z_wdata),
        .rdata(z_rdata), .ready(z_ready), .err(z_err)
    );

    // Reference model: memory as a flat byte array
    logic [7:0] mem_m [NBYTES];

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;
    exp_t sb_q[$];

    function automatic void model(input logic w, input logic [2:0] f,
                                  input logic [31:0] a, input logic [31:0] d,
                                  input bit commit,
                                  output logic [31:0] r, output logic e);
        int size;
        logic [31:0] val;
        size = 0;
        if (w) begin
            if (f == 3'd0) size = 1;
            else if (f == 3'd1) size = 2;
            else if (f == 3'd2) size = 4;
        end else begin
            if (f == 3'd0 || f == 3'd4) size = 1;
            else if (f == 3'd1 || f == 3'd5) size = 2;
            else if (f == 3'd2) size = 4;
        end
        e = (size == 0) || (a >= NBYTES) || ((a % size) != 0);
        r = 32'd0;
        if (!e) begin
            if (w) begin
                if (commit)
                    for (int i = 0; i < size; i++) mem_m[a + i] = d[8*i +: 8];
            end else begin
                val = 32'd0;
                for (int i = 0; i < size; i++) val = val | (32'(mem_m[a + i]) << (8 * i));
                if (!f[2] && size < 4 && val[8*size-1]) val = val | (32'hFFFF_FFFF << (8 * size));
                r = val;
            end
        end
    endfunction

    // Issue one request in an IDLE cycle, scramble the inputs while busy,
    // and return during the cycle that shows ready. Leaves reset released.
    task automatic do_req(input logic w, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] d, input bit commit);
        exp_t x;
        int n;
        @(negedge clk);
        reset = 1'b1;
        req_valid = 1'b1; we = w; funct3 = f; addr = a; wdata = d;
        model(w, f, a, d, commit, x.rdata, x.err);
        x.acc = cyc + 1;
        sb_q.push_back(x);
        @(negedge clk);
        n = 0;
        while (!ready) begin
            if (n == 50) begin
                checks++; errors++;
                $display("FAIL ready_timeout addr=%h: no ready within 50 cycles", a);
                break;
            end
            req_valid = 1'($urandom_range(0, 1));
            we = 1'($urandom_range(0, 1));
            funct3 = 3'($urandom_range(0, 7));
            addr = $urandom;
            wdata = $urandom;
            @(negedge clk);
            n++;
        end
        req_valid = 1'b0;
    endtask

    // Monitor: every cycle, idle outputs must be zero; responses are popped
    // from the scoreboard. ready is visible in the (WAIT+1)th cycle after the
    // accepting edge, i.e. WAIT edges after it.
    always @(negedge clk) begin
        exp_t x;
        if (ready) begin
            if (sb_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_ready: ready=1 with no outstanding request");
            end else begin
                x = sb_q.pop_front();
                checks++;
                if (rdata !== x.rdata || err !== x.err) begin
                    errors++;
                    $display("FAIL resp_data: got rdata=%h err=%b, expected rdata=%h err=%b",
                             rdata, err, x.rdata, x.err);
                end
                checks++;
                if (cyc - x.acc != WAIT) begin
                    errors++;
                    $display("FAIL latency: ready %0d edges after accept, expected %0d",
                             cyc - x.acc, WAIT);
                end
            end
        end else begin
            checks++;
            if (err !== 1'b0 || rdata !== 32'd0) begin
                errors++;
                $display("FAIL idle_outputs: err=%b rdata=%h, expected 0 while ready=0", err, rdata);
            end
        end
    end

    task automatic chk_zero(input string name);
        checks++;
        if (ready !== 1'b0 || err !== 1'b0 || rdata !== 32'd0) begin
            errors++;
            $display("FAIL %s: ready=%b err=%b rdata=%h, expected all 0", name, ready, err, rdata);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] v;
        logic        w;

        // Reset state, with reset held low
        #12;
        chk_zero("reset_state");
        checks++;
        if (z_ready !== 1'b0 || z_err !== 1'b0 || z_rdata !== 32'd0) begin
            errors++;
            $display("FAIL reset_state_w0: ready=%b err=%b rdata=%h, expected all 0",
                     z_ready, z_err, z_rdata);
        end

        // First request is driven in the cycle reset releases
        do_req(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, 1'b1);
        do_req(1'b0, 3'd2, 32'h10, 32'd0, 1'b1);

        // Give every word a defined value
        for (int i = 0; i < DEPTH; i++) do_req(1'b1, 3'd2, 32'(i * 4), $urandom, 1'b1);

        do_req(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, 1'b1);
        do_req(1'b0, 3'd2, 32'h10, 32'd0, 1'b1);

        do_req(1'b1, 3'd2, 32'h10, 32'h0000_0000, 1'b1);
        do_req(1'b1, 3'd0, 32'h11, 32'h0000_0080, 1'b1);
        do_req(1'b0, 3'd0, 32'h11, 32'd0, 1'b1);
        do_req(1'b0, 3'd4, 32'h11, 32'd0, 1'b1);
        do_req(1'b0, 3'd2, 32'h10, 32'd0, 1'b1);

        do_req(1'b1, 3'd1, 32'h21, 32'h0000_1234, 1'b1);
        do_req(1'b0, 3'd2, 32'h22, 32'd0, 1'b1);
        do_req(1'b0, 3'd2, 32'h20, 32'd0, 1'b1);
        do_req(1'b0, 3'd2, 32'h400, 32'd0, 1'b1);
        do_req(1'b1, 3'd3, 32'h24, 32'h5555_5555, 1'b1);
        do_req(1'b0, 3'd6, 32'h24, 32'd0, 1'b1);
        do_req(1'b0, 3'd2, 32'h24, 32'd0, 1'b1);

        // Reset pulsed during WAIT of a store: outputs drop, store is lost
        do_req(1'b1, 3'd2, 32'h30, 32'h1111_2222, 1'b1);
        @(negedge clk);
        req_valid = 1'b1; we = 1'b1; funct3 = 3'd2; addr = 32'h30; wdata = 32'hAAAA_5555;
        @(negedge clk);
        req_valid = 1'b0;
        #2 reset = 1'b0;
        #1 chk_zero("reset_in_wait");
        do_req(1'b0, 3'd2, 32'h30, 32'd0, 1'b1);

        // Reset pulsed during RESP of a store: ready drops at once, no commit
        do_req(1'b1, 3'd2, 32'h30, 32'h9999_8888, 1'b0);
        #2 reset = 1'b0;
        #1 chk_zero("reset_in_resp");
        do_req(1'b0, 3'd2, 32'h30, 32'd0, 1'b1);

        // Randomized mix of loads and stores
        for (int i = 0; i < 300; i++) begin
            w = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) f = 3'($urandom_range(0, 7));
            else if (w) f = 3'($urandom_range(0, 2));
            else begin
                case ($urandom_range(0, 4))
                    0: f = 3'd0; 1: f = 3'd1; 2: f = 3'd2; 3: f = 3'd4; default: f = 3'd5;
                endcase
            end
            if ($urandom_range(0, 15) == 0) a = $urandom;
            else a = 32'($urandom_range(0, NBYTES - 1));
            if ($urandom_range(0, 1) == 0) a[1:0] = 2'b00;
            do_req(w, f, a, $urandom, 1'b1);
        end

        // No-wait instance: req_valid held high, alternating sw/lw
        @(negedge clk);
        v = $urandom;
        z_req_valid = 1'b1; z_we = 1'b1; z_funct3 = 3'd2;
        z_addr = 32'($urandom_range(0, DEPTH - 1) * 4); z_wdata = v;
        for (int n = 1; n <= 16; n++) begin
            @(negedge clk);
            checks++;
            if (z_ready !== n[0]) begin
                errors++;
                $display("FAIL w0_cadence cycle %0d: ready=%b expected %b", n, z_ready, n[0]);
            end
            if (z_ready) begin
                checks++;
                if (z_rdata !== (z_we ? 32'd0 : v) || z_err !== 1'b0) begin
                    errors++;
                    $display("FAIL w0_resp: rdata=%h err=%b expected rdata=%h err=0",
                             z_rdata, z_err, z_we ? 32'd0 : v);
                end
                if (z_we) begin
                    z_we = 1'b0;
                end else begin
                    v = $urandom;
                    z_we = 1'b1;
                    z_addr = 32'($urandom_range(0, DEPTH - 1) * 4);
                    z_wdata = v;
                end
            end
        end
        z_req_valid = 1'b0;

        repeat (5) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d responses outstanding, expected 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
